// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one pipelined multiplier among N_REQ requesters.
// A shift-register of {valid,id} tags tracks each issued operation so its product returns tagged.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int MUL_LAT = 3,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*W-1:0]           req_a,
    input  logic [N_REQ*W-1:0]           req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic [W-1:0]                 mul_a,
    output logic [W-1:0]                 mul_b,
    input  logic [2*W-1:0]               mul_p,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic [2*W-1:0]               rsp_data,
    output logic [$clog2(MUL_LAT+1)-1:0] inflight
);

    localparam int CW = $clog2(MUL_LAT + 1);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [W-1:0]       mul_a_q, mul_a_d;
    logic [W-1:0]       mul_b_q, mul_b_d;
    logic [MUL_LAT-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [MUL_LAT];
    logic               rsp_vld_q;
    logic [IDW-1:0]     rsp_id_q;

    logic               found;
    logic [IDW-1:0]     winner;
    logic [CW-1:0]      inflight_cnt;
    int                 idx;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        ptr_d     = ptr_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        if (found) begin
            req_ready = N_REQ'(1) << winner;
            ptr_d     = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            mul_a_d   = req_a[winner*W +: W];
            mul_b_d   = req_b[winner*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            tag_vld_q[0] <= found;
            tag_id_q[0]  <= winner;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            // Extra stage because the multiplier only sees operands one edge after the grant.
            rsp_vld_q <= tag_vld_q[MUL_LAT-1];
            rsp_id_q  <= tag_id_q[MUL_LAT-1];
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int k = 0; k < MUL_LAT; k++) begin
            inflight_cnt = inflight_cnt + CW'(tag_vld_q[k]);
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = mul_p;
    assign inflight  = inflight_cnt;

endmodule
